// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined SEG-bit-per-stage ripple-carry adder/subtractor with valid/ready flow control
// Optional overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
   logic [STAGES-1:0][WIDTH-1:0] r_q, r_d;
   logic [STAGES-1:0]            c_q, c_d;

   // Per-stage inputs: stage 0 sees the port operands, later stages see the previous stage's registers.
   logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, r_in;
   logic [STAGES-1:0]            c_in, v_in;
   logic [STAGES-1:0][SEG:0]     slice_sum;
   logic                         stall;
   logic                         unused_bits;

   assign stall    = valid_q[LAST] && !out_ready;
   assign in_ready = !stall;

   always_comb begin
      a_in[0] = a;
      b_in[0] = sub ? ~b : b;
      r_in[0] = '0;
      c_in[0] = sub ? ~ci : ci;
      v_in[0] = in_valid;
      for (int s = 1; s < STAGES; s++) begin
         a_in[s] = a_q[s-1];
         b_in[s] = b_q[s-1];
         r_in[s] = r_q[s-1];
         c_in[s] = c_q[s-1];
         v_in[s] = valid_q[s-1];
      end

      for (int s = 0; s < STAGES; s++) begin
         slice_sum[s] = {1'b0, a_in[s][s*SEG +: SEG]} + {1'b0, b_in[s][s*SEG +: SEG]}
                      + {{SEG{1'b0}}, c_in[s]};
         r_d[s]                = r_in[s];
         r_d[s][s*SEG +: SEG]  = slice_sum[s][SEG-1:0];
         c_d[s]                = slice_sum[s][SEG];
         a_d[s]                = a_in[s];
         b_d[s]                = b_in[s];
         valid_d[s]            = v_in[s];
      end

      // A stalled output freezes the whole pipe, bubbles included.
      if (stall) begin
         valid_d = valid_q;
         a_d     = a_q;
         b_d     = b_q;
         r_d     = r_q;
         c_d     = c_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         c_q     <= c_d;
      end
   end

   // Already-consumed operand slices in the skew registers are never read again.
   assign unused_bits = ^{a_q, b_q};

   assign out_valid = valid_q[LAST];
   assign sum       = r_q[LAST];
   assign carry     = c_q[LAST];

`ifdef ADDER_PIPE_OVF_EN
   logic ovf_q, ovf_d;

   // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
   always_comb begin
      ovf_d = ovf_q;
      if (!stall) begin
         ovf_d = (a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ slice_sum[LAST][SEG-1])
               ^ slice_sum[LAST][SEG];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe (SEG=4, 16 and 1 instances)
module tb_adder_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_v  [3];
   logic        in_ready_v  [3];
   logic [15:0] a_v         [3];
   logic [15:0] b_v         [3];
   logic        ci_v        [3];
   logic        sub_v       [3];
   logic        out_valid_v [3];
   logic        out_ready_v [3];
   logic [15:0] sum_v       [3];
   logic        carry_v     [3];
   logic        ovf_v       [3];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   adder_pipe #(.WIDTH(16), .SEG(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a_v[0]), .b(b_v[0]), .ci(ci_v[0]), .sub(sub_v[0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .sum(sum_v[0]), .carry(carry_v[0]), .ovf(ovf_v[0]));

   adder_pipe #(.WIDTH(16), .SEG(16)) u_dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a_v[1]), .b(b_v[1]), .ci(ci_v[1]), .sub(sub_v[1]),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .sum(sum_v[1]), .carry(carry_v[1]), .ovf(ovf_v[1]));

   adder_pipe #(.WIDTH(16), .SEG(1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a_v[2]), .b(b_v[2]), .ci(ci_v[2]), .sub(sub_v[2]),
      .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
      .sum(sum_v[2]), .carry(carry_v[2]), .ovf(ovf_v[2]));

   // Reference: plain integer arithmetic, returns {ovf, carry, sum}.
   function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
      int        u, sg;
      logic      cy, ov;
      logic [15:0] r;
      if (!s) begin
         u  = int'(x) + int'(y) + int'(c);
         cy = (u > 65535);
         sg = int'($signed(x)) + int'($signed(y)) + int'(c);
      end else begin
         u  = int'(x) - int'(y) - int'(c);
         cy = (u >= 0);
         sg = int'($signed(x)) - int'($signed(y)) - int'(c);
      end
      r = 16'(u);
`ifdef ADDER_PIPE_OVF_EN
      ov = (sg > 32767) || (sg < -32768);
`else
      ov = 1'b0;
`endif
      return {ov, cy, r};
   endfunction

   task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic s, output logic [17:0] res, output int lat);
      @(negedge clk);
      in_valid_v[0] = 1'b1; a_v[0] = x; b_v[0] = y; ci_v[0] = c; sub_v[0] = s;
      out_ready_v[0] = 1'b1;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      lat = 1;
      while (!out_valid_v[0] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      res = {ovf_v[0], carry_v[0], sum_v[0]};
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (out_valid_v[k] !== 1'b0 || sum_v[k] !== 16'h0 || carry_v[k] !== 1'b0 ||
             ovf_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got ov=%b s=%h c=%b o=%b ir=%b, need 0 0000 0 0 1",
                     k, out_valid_v[k], sum_v[k], carry_v[k], ovf_v[k], in_ready_v[k]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_directed;
      logic [15:0] xs [4] = '{16'h00FF, 16'hFFFF, 16'h0005, 16'h7FFF};
      logic [15:0] ys [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
      logic        ss [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [17:0] want [4];
      logic [17:0] got;
      int          lat;
      want[0] = {1'b0, 1'b0, 16'h0100};
      want[1] = {1'b0, 1'b1, 16'h0000};
      want[2] = {1'b0, 1'b0, 16'hFFFE};
`ifdef ADDER_PIPE_OVF_EN
      want[3] = {1'b1, 1'b0, 16'h8000};
`else
      want[3] = {1'b0, 1'b0, 16'h8000};
`endif
      for (int i = 0; i < 4; i++) begin
         run_one(xs[i], ys[i], 1'b0, ss[i], got, lat);
         n_cmp++;
         if (lat !== 4) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: got %0d, need 4", i, lat);
         end
         n_cmp++;
         if (got !== want[i]) begin
            n_fail++;
            $display("FAIL directed_value[%0d]: got ovf/carry/sum=%h, need %h", i, got, want[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int sent = 0, got = 0, cyc = 0;
      int exp_q [$];
      int e;
      while (got < 6 && cyc < 60) begin
         @(negedge clk);
         in_valid_v[0] = (sent < 6);
         a_v[0] = 16'(sent); b_v[0] = 16'(sent + 1); ci_v[0] = 1'b0; sub_v[0] = 1'b0;
         out_ready_v[0] = !(cyc >= 5 && cyc < 8);
         #1;
         if (out_valid_v[0] && !out_ready_v[0]) begin
            n_cmp++;
            if (in_ready_v[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_in_ready: got %b, need 0", in_ready_v[0]);
            end
         end
         if (out_valid_v[0] && out_ready_v[0]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            n_cmp++;
            if (e < 0 || sum_v[0] !== 16'(e) || carry_v[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_result[%0d]: got sum=%h carry=%b, need sum=%h carry=0",
                        got, sum_v[0], carry_v[0], 16'(e));
            end
            got++;
         end
         if (in_valid_v[0] && in_ready_v[0]) begin
            exp_q.push_back(2 * sent + 1);
            sent++;
         end
         cyc++;
      end
      in_valid_v[0] = 1'b0;
      out_ready_v[0] = 1'b1;
      n_cmp++;
      if (got !== 6) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d results, need 6", got);
      end
      repeat (6) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_extra: got out_valid=%b after drain, need 0", out_valid_v[0]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [17:0] got;
      int          lat;
      out_ready_v[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid_v[0] = 1'b1; a_v[0] = 16'(100 + i); b_v[0] = 16'h0011;
         ci_v[0] = 1'b1; sub_v[0] = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1;
      a_v[0] = 16'h1234;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      n_cmp++;
      if (out_valid_v[0] !== 1'b0 || sum_v[0] !== 16'h0 || carry_v[0] !== 1'b0 ||
          in_ready_v[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_state: got ov=%b s=%h c=%b ir=%b, need 0 0000 0 1",
                  out_valid_v[0], sum_v[0], carry_v[0], in_ready_v[0]);
      end
      reset = 1'b0;
      run_one(16'h4321, 16'h1111, 1'b1, 1'b1, got, lat);
      n_cmp++;
      if (lat !== 4 || got !== ref_op(16'h4321, 16'h1111, 1'b1, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_mid_fresh: got lat=%0d res=%h, need lat=4 res=%h",
                  lat, got, ref_op(16'h4321, 16'h1111, 1'b1, 1'b1));
      end
   endtask

   task automatic test_random(input int k);
      logic [17:0] exp_q [$];
      logic [17:0] e, held;
      logic        hold_chk = 1'b0;
      int          sent = 0, got = 0, cyc = 0;
      while (got < 1000 && cyc < 20000) begin
         @(negedge clk);
         in_valid_v[k]  = (sent < 1000) && ($urandom_range(3) != 0);
         a_v[k]         = 16'($urandom);
         b_v[k]         = 16'($urandom);
         ci_v[k]        = 1'($urandom);
         sub_v[k]       = 1'($urandom);
         out_ready_v[k] = ($urandom_range(9) < 7);
         #1;
         if (hold_chk) begin
            n_cmp++;
            if (out_valid_v[k] !== 1'b1 || {ovf_v[k], carry_v[k], sum_v[k]} !== held) begin
               n_fail++;
               $display("FAIL rand_hold dut%0d: got ov=%b res=%h, need 1 %h",
                        k, out_valid_v[k], {ovf_v[k], carry_v[k], sum_v[k]}, held);
            end
         end
         if (out_valid_v[k] && out_ready_v[k]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
            n_cmp++;
            if ({ovf_v[k], carry_v[k], sum_v[k]} !== e) begin
               n_fail++;
               $display("FAIL rand_result dut%0d #%0d: got %h, need %h",
                        k, got, {ovf_v[k], carry_v[k], sum_v[k]}, e);
            end
            got++;
         end
         if (in_valid_v[k] && in_ready_v[k]) begin
            exp_q.push_back(ref_op(a_v[k], b_v[k], ci_v[k], sub_v[k]));
            sent++;
         end
         hold_chk = out_valid_v[k] && !out_ready_v[k];
         held     = {ovf_v[k], carry_v[k], sum_v[k]};
         cyc++;
      end
      in_valid_v[k] = 1'b0;
      n_cmp++;
      if (got !== 1000) begin
         n_fail++;
         $display("FAIL rand_count dut%0d: got %0d results, need 1000", k, got);
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; ci_v[k] = 1'b0;
         sub_v[k] = 1'b0; out_ready_v[k] = 1'b1;
      end
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random(0);
      test_random(1);
      test_random(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
